dm_responder: RTL
=================

Name: dm_responder

Overview:
- Memory-side responder for processor data-memory accesses; the target end of the load/store request channel.
- Accepts one request at a time over a req/ack handshake.
- Inserts a configurable number of wait states, performs a word read or write on internal storage, and returns data with a one-cycle ack.
- Sits between the processor's data-access port and the data storage; lets the datapath be tested against a slow memory.

Parameters:
ADDR_W, 8, word-index width; storage holds 2**ADDR_W 32-bit words
WAIT_CYCLES, 2, wait states between request capture and response (0..15)

Ports:
CLK  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
req  input  1  request valid; sampled only in IDLE
we  input  1  1 = write, 0 = read; captured with req
addr  input  32  byte address; word index = addr[ADDR_W+1:2]
wdata  input  32  write data; captured with req
rdata  output  32  read data; valid only while ack=1
ack  output  1  one-cycle response strobe
err  output  1  qualifies ack: access rejected
busy  output  1  high in WAIT and RESP

Behaviour:
- Interface: one clock CLK; reset rst is asynchronous and active-high.
- Reset state: IDLE; ack=0, err=0, busy=0, rdata=0, wait counter=0.
- Reset does not clear storage contents.
- FSM states: IDLE, WAIT, RESP.
- IDLE with req=1:
  - latch we, addr, wdata.
  - if WAIT_CYCLES=0, go to RESP; otherwise load counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement counter each cycle; go to RESP on the edge where counter=0.
- RESP: ack=1 for exactly one cycle, then back to IDLE unconditionally.
- Latency: ack asserts WAIT_CYCLES+1 cycles after the req edge.
- Commit point:
  - A write commits on the edge entering RESP, never earlier.
  - A read samples storage on the same edge, so rdata is registered and stable while ack=1.
- Error checks, evaluated on latched addr:
  - misaligned: addr[1:0]!=0
  - out of range: addr[31:ADDR_W+2]!=0
  - On error: err=1 with ack, no write, rdata=0.
- rdata and err return to 0 the cycle after ack.
- Requester rules:
  - hold req until ack, then deassert it in the ack cycle.
  - req still high in the cycle after ack is taken as a new request; back-to-back accesses give at most one accepted request per WAIT_CYCLES+2 cycles.
- Inputs are ignored outside IDLE; changing addr/wdata mid-request has no effect.
- Reset mid-request:
  - returns to IDLE immediately.
  - a write not yet committed is discarded.
  - no ack is produced for the aborted request.
- Read-after-write to the same word on consecutive requests returns the new data.

Optional Feature:
- Macro: DM_BYTE_STROBE_EN
- Defined:
  - adds input be[3:0], captured with req.
  - a write updates only the bytes whose be bit is 1; be=0000 is a legal no-op write with ack and err=0.
  - reads ignore be.
- Undefined:
  - no be port.
  - every write updates the full word.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - the word width constant 32
  - the WAIT_CYCLES counter width (4)
- One sub-module is natural: dm_storage_array.
  - synchronous single-port word array with write enable (and byte strobes when DM_BYTE_STROBE_EN is defined).
  - contains no handshake logic.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → ack=0, err=0, busy=0, rdata=0 immediately, without waiting for a CLK edge.
- Write then read, WAIT_CYCLES=2: write addr=0x0000_0010, wdata=0xDEAD_BEEF, then read 0x10 → each ack exactly 3 cycles after req; read rdata=0xDEAD_BEEF, err=0.
- WAIT_CYCLES=0: read request → ack in the next cycle; busy high for exactly 1 cycle.
- Errors:
  - read addr=0x0000_0013 → ack with err=1, rdata=0.
  - write addr=0x0000_0400 (ADDR_W=8) → ack with err=1; a following read of word 0 is unchanged.
- Reset mid-write: issue write 0x1234_5678 to 0x20, assert rst during WAIT → no ack; a later read of 0x20 returns the old contents.
- DM_BYTE_STROBE_EN defined: word 0x8 holds 0xAABB_CCDD; write 0x1122_3344 with be=0101 → a read of 0x8 returns 0xAA22_CC44.

Source files
------------

// File: rtl/dm_responder_pkg.sv
// Shared types and constants for the dm_responder data-memory target.
// Optional byte-strobe support is selected with the DM_BYTE_STROBE_EN macro.
package dm_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    // An access is rejected when misaligned or beyond the implemented word range.
    function automatic logic addr_err(input logic [31:0] a, input int unsigned addr_w);
        logic [31:0] hi;
        hi = a >> (addr_w + 32'd2);
        return (a[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/dm_storage_array.sv
// Single-port word storage: synchronous write, combinational read, no reset.
// With DM_BYTE_STROBE_EN defined, writes honour per-byte enables.
module dm_storage_array
    import dm_responder_pkg::*;
#(
    parameter int ADDR_W = 8
)
(
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] idx,
    input  logic [WORD_W-1:0] wr_data,
`ifdef DM_BYTE_STROBE_EN
    input  logic [3:0]        wr_be,
`endif
    output logic [WORD_W-1:0] rd_data
);

    localparam int DEPTH = int'(32'd1 << ADDR_W);

    logic [WORD_W-1:0] mem_r [DEPTH];

    assign rd_data = mem_r[idx];

    // Word (or byte-lane) write on the clock edge when enabled.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
`ifdef DM_BYTE_STROBE_EN
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_r[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
`else
            mem_r[idx] <= wr_data;
`endif
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: req/ack target with WAIT_CYCLES wait states.
// Define DM_BYTE_STROBE_EN to add the be[3:0] byte-strobe input.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
)
(
    input  logic        CLK,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef DM_BYTE_STROBE_EN
    input  logic [3:0]  be,
`endif
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 32'sd0) ?
                                            CNT_W'(WAIT_CYCLES - 32'sd1) : CNT_ZERO;
    localparam bit NO_WAIT = (WAIT_CYCLES == 32'sd0);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              we_r;
    logic [31:0]       addr_r, wdata_r;
    logic [31:0]       rdata_r;
    logic              ack_r, err_r, busy_r;

    logic              eff_we_s;
    logic [31:0]       eff_addr_s, eff_wdata_s;
    logic [3:0]        eff_be_s;
    logic              bad_s, enter_resp_s, wr_en_s;
    logic [WORD_W-1:0] rd_word_s;

`ifdef DM_BYTE_STROBE_EN
    logic [3:0]        be_r;
`endif

    // Next-state and wait-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    if (NO_WAIT) begin
                        state_s = ST_RESP;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = CNT_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_RESP;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // In IDLE the live inputs are the request (zero-wait path); otherwise the latched copy.
    always_comb begin
        if (state_r == ST_IDLE) begin
            eff_we_s    = we;
            eff_addr_s  = addr;
            eff_wdata_s = wdata;
`ifdef DM_BYTE_STROBE_EN
            eff_be_s    = be;
`else
            eff_be_s    = 4'hF;
`endif
        end else begin
            eff_we_s    = we_r;
            eff_addr_s  = addr_r;
            eff_wdata_s = wdata_r;
`ifdef DM_BYTE_STROBE_EN
            eff_be_s    = be_r;
`else
            eff_be_s    = 4'hF;
`endif
        end
        enter_resp_s = (state_s == ST_RESP);
        bad_s        = addr_err(eff_addr_s, ADDR_W);
        wr_en_s      = enter_resp_s && eff_we_s && !bad_s;
    end

    dm_storage_array #(.ADDR_W(ADDR_W)) u_storage (
        .CLK     (CLK),
        .wr_en   (wr_en_s),
        .idx     (eff_addr_s[ADDR_W+1:2]),
        .wr_data (eff_wdata_s),
`ifdef DM_BYTE_STROBE_EN
        .wr_be   (eff_be_s),
`endif
        .rd_data (rd_word_s)
    );

    // State, request capture and registered response outputs.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            we_r    <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
`ifdef DM_BYTE_STROBE_EN
            be_r    <= 4'h0;
`endif
            rdata_r <= 32'd0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if ((state_r == ST_IDLE) && req) begin
                we_r    <= we;
                addr_r  <= addr;
                wdata_r <= wdata;
`ifdef DM_BYTE_STROBE_EN
                be_r    <= be;
`endif
            end
            ack_r   <= enter_resp_s;
            err_r   <= enter_resp_s && bad_s;
            rdata_r <= (enter_resp_s && !eff_we_s && !bad_s) ? rd_word_s : 32'd0;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign rdata = rdata_r;
    assign ack   = ack_r;
    assign err   = err_r;
    assign busy  = busy_r;

    logic unused_s;
    assign unused_s = ^eff_be_s;

endmodule
